dpram_port_arbiter: RTL
=======================

# dpram_port_arbiter

Arbitration and sequencing front end for the design's dual-port RAM (one write port, one registered-address read port). It shares each RAM port between two requesters with independent round-robin arbiters and returns read data with one-cycle latency on a tagged valid. A built-in clear engine zero-fills the whole array before each recognition frame.

## Interface
Parameters:
- WIDTH, 8, RAM data width
- DEPTH, 10, RAM address width (array holds 2**DEPTH words)

Ports:
- clock  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high
- clr_start  in  1  pulse, request full-array zero fill
- clr_busy  out  1  high while clear engine owns the RAM
- wr0_req, wr1_req  in  1  write request, held until granted
- wr0_addr, wr1_addr  in  DEPTH  write address
- wr0_data, wr1_data  in  WIDTH  write data
- wr0_gnt, wr1_gnt  out  1  combinational grant; write commits at this clock edge
- rd0_req, rd1_req  in  1  read request, held until granted
- rd0_addr, rd1_addr  in  DEPTH  read address
- rd0_gnt, rd1_gnt  out  1  combinational grant; address captured at this edge
- rd0_valid, rd1_valid  out  1  registered, rd_data belongs to this requester
- rd_data  out  WIDTH  shared read data (passthrough of ram_q)
- ram_wren  out  1  to RAM wren
- ram_wraddress  out  DEPTH  to RAM wraddress
- ram_data  out  WIDTH  to RAM data
- ram_rdaddress  out  DEPTH  to RAM rdaddress
- ram_q  in  WIDTH  from RAM q

## Operation
- FSM states: IDLE, CLEAR. Reset -> IDLE.
- IDLE -> CLEAR when clr_start=1 sampled in IDLE; clr_start ignored in CLEAR.
- CLEAR: counter clr_addr starts at 0; each cycle ram_wren=1, ram_wraddress=clr_addr, ram_data=0, clr_addr+1. After the write of address 2**DEPTH-1, go to IDLE and clear clr_addr to 0. The counter is DEPTH+1 bits or uses terminal compare; it never wraps into a second pass.
- In CLEAR all four gnt outputs are 0; requesters stall.
- Write arbiter (IDLE only): one request wins outright. If both request, the side named by wr_ptr wins. After any write grant to side i, wr_ptr <= other side. wr_ptr reset value 0 (side 0 preferred).
- Granted write: ram_wren=1, ram_wraddress/ram_data from the winner. With no grant and not clearing: ram_wren=0, address/data driven 0.
- Read arbiter: identical rules, independent pointer rd_ptr (reset 0). Granted read drives ram_rdaddress=winner addr; otherwise ram_rdaddress=0.
- Read return: rdN_valid <= rdN_gnt (registered); rd_data = ram_q combinational. At most one valid high per cycle.
- A same-cycle write and read to one address return the new data (write-first, inherent to the RAM's registered read address).
- clr_start sampled in IDLE in the same cycle as request grants: those grants complete normally; CLEAR starts next cycle.

## Timing
- Reset values: clr_busy=0, all gnt=0, all valid=0, ram_wren=0, ram_wraddress=0, ram_data=0, ram_rdaddress=0, wr_ptr=rd_ptr=0, clr_addr=0.
- Grants are combinational from req, state and pointer in the same cycle. No grant is issued when req=0.
- Write latency: data in RAM at the edge ending the grant cycle.
- Read latency 1: grant in cycle N, rdN_valid=1 and rd_data valid in cycle N+1. Back-to-back reads give one result per cycle.
- clr_busy = (state==CLEAR), high from the cycle after clr_start for exactly 2**DEPTH cycles.
- Reset mid-CLEAR: next cycle IDLE, clr_busy=0, clr_addr=0. The partial fill is left as is. Reset also drops pending valids.
- Throughput: one write plus one read per cycle in IDLE.

## Test plan
- Reset: hold reset 2 cycles with all reqs high -> all gnt/valid/ram_wren/clr_busy 0 during reset. First cycle after reset, wr0_gnt=1 and rd0_gnt=1 (pointers 0).
- Write then read: wr0 addr 0x05 data 0xA5, then rd1 addr 0x05 -> rd1_gnt the same cycle, rd1_valid=1 and rd_data=0xA5 the next cycle, rd0_valid=0.
- Contention: wr0 and wr1 both held for 4 cycles (addrs 1,2, distinct data) -> grants alternate 0,1,0,1. Same check on reads: valids alternate and data matches each address.
- Write-first: the same cycle writes 0x3C to addr 0x10 and grants a read of 0x10 -> next cycle rd_data=0x3C.
- Clear: DEPTH=4, preload nonzero, pulse clr_start -> clr_busy high exactly 16 cycles, gnts held 0 while reqs asserted, then reads of all 16 addresses return 0.
- Reset during clear: DEPTH=4, assert reset at clear cycle 7 -> clr_busy=0 next cycle. Addrs 0-6 read 0, addrs 7-15 keep old data. A new clr_start restarts at address 0.

Source files
------------

// File: rtl/dpram_port_arbiter_if.sv
// Requester handshakes plus the RAM port bundle seen by dpram_port_arbiter.
interface dpram_port_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 10
);
  logic             clr_start;
  logic             clr_busy;
  logic             wr0_req,  wr1_req;
  logic [DEPTH-1:0] wr0_addr, wr1_addr;
  logic [WIDTH-1:0] wr0_data, wr1_data;
  logic             wr0_gnt,  wr1_gnt;
  logic             rd0_req,  rd1_req;
  logic [DEPTH-1:0] rd0_addr, rd1_addr;
  logic             rd0_gnt,  rd1_gnt;
  logic             rd0_valid, rd1_valid;
  logic [WIDTH-1:0] rd_data;
  logic             ram_wren;
  logic [DEPTH-1:0] ram_wraddress;
  logic [WIDTH-1:0] ram_data;
  logic [DEPTH-1:0] ram_rdaddress;
  logic [WIDTH-1:0] ram_q;

  // Arbiter side: sees requests and RAM read data, drives grants and RAM controls.
  modport slave (
    input  clr_start,
    input  wr0_req, wr1_req, wr0_addr, wr1_addr, wr0_data, wr1_data,
    input  rd0_req, rd1_req, rd0_addr, rd1_addr,
    input  ram_q,
    output clr_busy,
    output wr0_gnt, wr1_gnt, rd0_gnt, rd1_gnt,
    output rd0_valid, rd1_valid, rd_data,
    output ram_wren, ram_wraddress, ram_data, ram_rdaddress
  );

  // Requester / RAM side: the mirror image.
  modport master (
    output clr_start,
    output wr0_req, wr1_req, wr0_addr, wr1_addr, wr0_data, wr1_data,
    output rd0_req, rd1_req, rd0_addr, rd1_addr,
    output ram_q,
    input  clr_busy,
    input  wr0_gnt, wr1_gnt, rd0_gnt, rd1_gnt,
    input  rd0_valid, rd1_valid, rd_data,
    input  ram_wren, ram_wraddress, ram_data, ram_rdaddress
  );
endinterface

// File: rtl/dpram_port_arbiter.sv
// Dual-port RAM front end: two round-robin arbiters (write port, read port),
// tagged one-cycle read return and a full-array zero-fill engine.
module dpram_port_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 10
) (
  input logic                 clock,
  input logic                 reset,
  dpram_port_arbiter_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DEPTH-1:0] r_clr_addr;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic             r_rd0_valid;
  logic             r_rd1_valid;

  logic             w_active;
  logic             w_clearing;
  logic             w_clr_last;
  logic             w_wr0_gnt, w_wr1_gnt;
  logic             w_rd0_gnt, w_rd1_gnt;
  logic             w_ram_wren;
  logic [DEPTH-1:0] w_ram_wraddress;
  logic [WIDTH-1:0] w_ram_data;
  logic [DEPTH-1:0] w_ram_rdaddress;

  // Everything toward the RAM is held quiet while reset is asserted, so a reset
  // that lands mid-clear does not write the address the counter points at.
  assign w_active   = ~reset;
  assign w_clearing = w_active && (r_state == CLEAR);
  // Terminal compare: the pass ends on the last address and never wraps.
  assign w_clr_last = (r_clr_addr == {DEPTH{1'b1}});

  // Next state, round-robin grants and RAM port muxing.
  // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_wr0_gnt       = 1'b0;
    w_wr1_gnt       = 1'b0;
    w_rd0_gnt       = 1'b0;
    w_rd1_gnt       = 1'b0;
    w_ram_wren      = 1'b0;
    w_ram_wraddress = '0;
    w_ram_data      = '0;
    w_ram_rdaddress = '0;

    case (r_state)
      IDLE: begin
        if (bus.clr_start) w_state_nxt = CLEAR;
        if (w_active) begin
          // Lone requester wins; on contention the pointer names the winner.
          w_wr0_gnt = bus.wr0_req && (!bus.wr1_req || !r_wr_ptr);
          w_wr1_gnt = bus.wr1_req && (!bus.wr0_req ||  r_wr_ptr);
          w_rd0_gnt = bus.rd0_req && (!bus.rd1_req || !r_rd_ptr);
          w_rd1_gnt = bus.rd1_req && (!bus.rd0_req ||  r_rd_ptr);
        end
      end
      CLEAR: begin
        if (w_clr_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_clearing) begin
      w_ram_wren      = 1'b1;
      w_ram_wraddress = r_clr_addr;
    end else if (w_wr0_gnt) begin
      w_ram_wren      = 1'b1;
      w_ram_wraddress = bus.wr0_addr;
      w_ram_data      = bus.wr0_data;
    end else if (w_wr1_gnt) begin
      w_ram_wren      = 1'b1;
      w_ram_wraddress = bus.wr1_addr;
      w_ram_data      = bus.wr1_data;
    end

    if (w_rd0_gnt)      w_ram_rdaddress = bus.rd0_addr;
    else if (w_rd1_gnt) w_ram_rdaddress = bus.rd1_addr;
  end

  // State register, clear counter, arbitration pointers and read-return tags.
  // NOTE: non-blocking assignments here so every register updates from pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_clr_addr  <= '0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_rd0_valid <= 1'b0;
      r_rd1_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clearing) r_clr_addr <= w_clr_last ? '0 : r_clr_addr + 1'b1;
      // After a grant the other side becomes preferred.
      if (w_wr0_gnt)      r_wr_ptr <= 1'b1;
      else if (w_wr1_gnt) r_wr_ptr <= 1'b0;
      if (w_rd0_gnt)      r_rd_ptr <= 1'b1;
      else if (w_rd1_gnt) r_rd_ptr <= 1'b0;
      r_rd0_valid <= w_rd0_gnt;
      r_rd1_valid <= w_rd1_gnt;
    end
  end

  assign bus.clr_busy      = (r_state == CLEAR);
  assign bus.wr0_gnt       = w_wr0_gnt;
  assign bus.wr1_gnt       = w_wr1_gnt;
  assign bus.rd0_gnt       = w_rd0_gnt;
  assign bus.rd1_gnt       = w_rd1_gnt;
  assign bus.rd0_valid     = r_rd0_valid;
  assign bus.rd1_valid     = r_rd1_valid;
  assign bus.rd_data       = bus.ram_q;
  assign bus.ram_wren      = w_ram_wren;
  assign bus.ram_wraddress = w_ram_wraddress;
  assign bus.ram_data      = w_ram_data;
  assign bus.ram_rdaddress = w_ram_rdaddress;
endmodule
